// File: rtl/conv1d_engine_if.sv
// Bus bundle for conv1d_engine: start/status handshake plus the kernel-read,
// signal-read and result-write SRAM ports. The engine side uses "master";
// the surrounding SRAMs/controller side uses "slave".
interface conv1d_engine_if #(
  parameter int Data_Width_In  = 8,
  parameter int Data_Width_Out = 16,
  parameter int Addr_Width     = 4,
  parameter int Para_Deg       = 2
);
  logic                                Start;
  logic                                Busy;
  logic                                Done;

  logic                                Kern_Chip_Select;
  logic                                Kern_En_Read;
  logic [Addr_Width-1:0]               Kern_Read_Addr;
  logic [Para_Deg*Data_Width_In-1:0]   Kern_Read_Data;

  logic                                In_Chip_Select;
  logic                                In_En_Read;
  logic [Addr_Width-1:0]               In_Read_Addr;
  logic [Para_Deg*Data_Width_In-1:0]   In_Read_Data;

  logic                                Out_Chip_Select;
  logic                                Out_En_Write;
  logic [Addr_Width-1:0]               Out_Write_Addr;
  logic [Para_Deg*Data_Width_Out-1:0]  Out_Write_Data;

  modport master (
    input  Start,
    output Busy, Done,
    output Kern_Chip_Select, Kern_En_Read, Kern_Read_Addr,
    input  Kern_Read_Data,
    output In_Chip_Select, In_En_Read, In_Read_Addr,
    input  In_Read_Data,
    output Out_Chip_Select, Out_En_Write, Out_Write_Addr, Out_Write_Data
  );

  modport slave (
    output Start,
    input  Busy, Done,
    input  Kern_Chip_Select, Kern_En_Read, Kern_Read_Addr,
    output Kern_Read_Data,
    input  In_Chip_Select, In_En_Read, In_Read_Addr,
    output In_Read_Data,
    input  Out_Chip_Select, Out_En_Write, Out_Write_Addr, Out_Write_Data
  );
endinterface

// File: rtl/conv1d_engine.sv
// Causal 1-D convolution engine: loads Kernel_Len taps from the kernel SRAM,
// streams Num_Words signal words (Para_Deg lanes each, lane0 earliest) and
// writes one result word per input word, two cycles after its read issue.
// Optional build macro CONV1D_SATURATE_EN: overflowing result lanes clamp to
// all-ones instead of wrapping modulo 2^Data_Width_Out.
//
// state  | meaning
// IDLE   | waiting for Start, history held at zero
// LOAD_W | issuing kernel word reads 0..KW-1
// RUN    | issuing signal word reads 0..Num_Words-1
// DRAIN  | waiting for the last result write
// DONE   | one-cycle Done pulse
module conv1d_engine #(
  parameter int Data_Width_In  = 8,
  parameter int Data_Width_Out = 16,
  parameter int Addr_Width     = 4,
  parameter int Ram_Depth      = 1 << Addr_Width,
  parameter int Para_Deg       = 2,
  parameter int Kernel_Len     = 3,
  parameter int Num_Words      = 16
) (
  input logic clk,
  input logic rst,
  conv1d_engine_if.master bus
);

  localparam int DWI = Data_Width_In;
  localparam int DWO = Data_Width_Out;
  localparam int PD  = Para_Deg;
  localparam int KL  = Kernel_Len;
  localparam int KW  = (KL + PD - 1) / PD;
  // Kernel_Len=1 keeps a one-entry history that is never referenced, so the
  // window indexing stays uniform.
  localparam int HL  = (KL > 1) ? KL - 1 : 1;
  localparam int WL  = HL + PD;
  localparam int LAST_WORD = ((Num_Words > Ram_Depth) ? Ram_Depth : Num_Words) - 1;
`ifdef CONV1D_SATURATE_EN
  // Full-precision sum so overflow can be detected.
  localparam int SUM_W = 2 * DWI + $clog2(KL + 1);
  localparam int ACC_W = (SUM_W > DWO) ? SUM_W : DWO + 1;
`else
  // Wrapping result: modulo arithmetic at output width is exact.
  localparam int ACC_W = DWO;
`endif

  localparam logic [Addr_Width-1:0] LAST_K = Addr_Width'(KW - 1);
  localparam logic [Addr_Width-1:0] LAST_X = Addr_Width'(LAST_WORD);

  typedef enum logic [2:0] {IDLE, LOAD_W, RUN, DRAIN, DONE} state_t;

  state_t                  state_q;
  logic                    busy_q, done_q;
  logic                    kern_rd_q, kern_vld_q;
  logic [Addr_Width-1:0]   kern_addr_q, kern_widx_q;
  logic                    in_rd_q, in_vld_q;
  logic [Addr_Width-1:0]   in_addr_q, in_vaddr_q;
  logic                    out_wr_q;
  logic [Addr_Width-1:0]   out_addr_q;
  logic [PD*DWO-1:0]       out_data_q;
  logic [DWI-1:0]          taps_q [KL];
  logic [DWI-1:0]          hist_q [HL];

  logic [DWI-1:0]          win_d  [WL];
  logic [ACC_W-1:0]        acc_d  [PD];
  logic [PD*DWO-1:0]       res_d;

  assign bus.Busy             = busy_q;
  assign bus.Done             = done_q;
  assign bus.Kern_Chip_Select = kern_rd_q;
  assign bus.Kern_En_Read     = kern_rd_q;
  assign bus.Kern_Read_Addr   = kern_addr_q;
  assign bus.In_Chip_Select   = in_rd_q;
  assign bus.In_En_Read       = in_rd_q;
  assign bus.In_Read_Addr     = in_addr_q;
  assign bus.Out_Chip_Select  = out_wr_q;
  assign bus.Out_En_Write     = out_wr_q;
  assign bus.Out_Write_Addr   = out_addr_q;
  assign bus.Out_Write_Data   = out_data_q;

  // Sequencer: state, status flags and SRAM read issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      kern_rd_q   <= 1'b0;
      kern_addr_q <= '0;
      in_rd_q     <= 1'b0;
      in_addr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            state_q     <= LOAD_W;
            busy_q      <= 1'b1;
            kern_rd_q   <= 1'b1;
            kern_addr_q <= '0;
          end
        end
        LOAD_W: begin
          if (kern_addr_q == LAST_K) begin
            kern_rd_q   <= 1'b0;
            kern_addr_q <= '0;
            in_rd_q     <= 1'b1;
            in_addr_q   <= '0;
            state_q     <= RUN;
          end else begin
            kern_addr_q <= kern_addr_q + 1'b1;
          end
        end
        RUN: begin
          if (in_addr_q == LAST_X) begin
            in_rd_q   <= 1'b0;
            in_addr_q <= '0;
            state_q   <= DRAIN;
          end else begin
            in_addr_q <= in_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (out_wr_q && (out_addr_q == LAST_X)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Kernel capture: each returned word fills the taps it covers; lanes past
  // Kernel_Len are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      kern_vld_q  <= 1'b0;
      kern_widx_q <= '0;
      taps_q      <= '{default: '0};
    end else begin
      kern_vld_q  <= kern_rd_q;
      kern_widx_q <= kern_addr_q;
      if (kern_vld_q) begin
        for (int k = 0; k < KL; k++) begin
          if (kern_widx_q == Addr_Width'(k / PD))
            taps_q[k] <= bus.Kern_Read_Data[(k % PD)*DWI +: DWI];
        end
      end
    end
  end

  // Convolution of the sample window: win_d holds history (oldest first)
  // followed by the new lanes, so x[n-k] for lane j is win_d[HL+j-k].
  always_comb begin
    for (int m = 0; m < HL; m++) win_d[m] = hist_q[m];
    for (int j = 0; j < PD; j++) win_d[HL+j] = bus.In_Read_Data[j*DWI +: DWI];
    res_d = '0;
    for (int j = 0; j < PD; j++) begin
      acc_d[j] = '0;
      for (int k = 0; k < KL; k++)
        acc_d[j] = acc_d[j] + (ACC_W'(taps_q[k]) * ACC_W'(win_d[HL+j-k]));
`ifdef CONV1D_SATURATE_EN
      res_d[j*DWO +: DWO] = (|acc_d[j][ACC_W-1:DWO]) ? {DWO{1'b1}} : acc_d[j][DWO-1:0];
`else
      res_d[j*DWO +: DWO] = acc_d[j];
`endif
    end
  end

  // Result register, write strobe and sample history update.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_vld_q   <= 1'b0;
      in_vaddr_q <= '0;
      out_wr_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      hist_q     <= '{default: '0};
    end else begin
      in_vld_q   <= in_rd_q;
      in_vaddr_q <= in_addr_q;
      if (in_vld_q) begin
        out_wr_q   <= 1'b1;
        out_addr_q <= in_vaddr_q;
        out_data_q <= res_d;
      end else begin
        out_wr_q   <= 1'b0;
        out_addr_q <= '0;
        out_data_q <= '0;
      end
      if (state_q == IDLE) begin
        hist_q <= '{default: '0};
      end else if (in_vld_q) begin
        for (int m = 0; m < HL; m++) hist_q[m] <= win_d[m+PD];
      end
    end
  end

endmodule

// File: tb/tb_conv1d_engine.sv
// Bench for conv1d_engine: one three-tap instance and one single-tap
// instance, each with a small behavioural SRAM model and an activity log.
// Expected results come from a direct evaluation of the convolution sum.
`timescale 1ns/1ps
module tb_conv1d_engine;
  localparam int DWI = 8, DWO = 16, AW = 4, PD = 2, NW = 16, NS = PD * NW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv1d_engine_if #(.Data_Width_In(DWI), .Data_Width_Out(DWO), .Addr_Width(AW), .Para_Deg(PD)) bus3 ();
  conv1d_engine_if #(.Data_Width_In(DWI), .Data_Width_Out(DWO), .Addr_Width(AW), .Para_Deg(PD)) bus1 ();

  conv1d_engine #(.Data_Width_In(DWI), .Data_Width_Out(DWO), .Addr_Width(AW), .Ram_Depth(16),
                  .Para_Deg(PD), .Kernel_Len(3), .Num_Words(NW))
    u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
  conv1d_engine #(.Data_Width_In(DWI), .Data_Width_Out(DWO), .Addr_Width(AW), .Ram_Depth(16),
                  .Para_Deg(PD), .Kernel_Len(1), .Num_Words(NW))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [PD*DWI-1:0] kmem3 [16], xmem3 [16], kmem1 [16], xmem1 [16];

  always @(posedge clk) begin
    if (bus3.Kern_Chip_Select && bus3.Kern_En_Read) bus3.Kern_Read_Data <= kmem3[bus3.Kern_Read_Addr];
    if (bus3.In_Chip_Select && bus3.In_En_Read)     bus3.In_Read_Data   <= xmem3[bus3.In_Read_Addr];
    if (bus1.Kern_Chip_Select && bus1.Kern_En_Read) bus1.Kern_Read_Data <= kmem1[bus1.Kern_Read_Addr];
    if (bus1.In_Chip_Select && bus1.In_En_Read)     bus1.In_Read_Data   <= xmem1[bus1.In_Read_Addr];
  end

  // Activity logs, sampled mid-cycle.
  int k_cyc[$], k_addr[$], i_cyc[$], i_addr[$], w_cyc[$], w_addr[$], d_cyc[$];
  logic [PD*DWO-1:0] w_data[$];
  int busy_first = -1, busy_last = -1, zviol = 0, csviol = 0;
  int k1_cnt = 0;
  int w1_cyc[$], d1_cyc[$];
  logic [PD*DWO-1:0] w1_data[$];

  always @(negedge clk) begin
    if (bus3.Kern_En_Read) begin k_cyc.push_back(cyc); k_addr.push_back(int'(bus3.Kern_Read_Addr)); end
    if (bus3.In_En_Read)   begin i_cyc.push_back(cyc); i_addr.push_back(int'(bus3.In_Read_Addr)); end
    if (bus3.Out_En_Write) begin
      w_cyc.push_back(cyc); w_addr.push_back(int'(bus3.Out_Write_Addr)); w_data.push_back(bus3.Out_Write_Data);
    end
    if (bus3.Done) d_cyc.push_back(cyc);
    if (bus3.Busy) begin if (busy_first < 0) busy_first = cyc; busy_last = cyc; end
    if (!bus3.Out_En_Write && bus3.Out_Write_Data != '0) zviol++;
    if (bus3.Kern_Chip_Select != bus3.Kern_En_Read || bus3.In_Chip_Select != bus3.In_En_Read ||
        bus3.Out_Chip_Select != bus3.Out_En_Write) csviol++;
    if (bus1.Kern_En_Read) k1_cnt++;
    if (bus1.Out_En_Write) begin w1_cyc.push_back(cyc); w1_data.push_back(bus1.Out_Write_Data); end
    if (bus1.Done) d1_cyc.push_back(cyc);
  end

  // Reference model: y[n] = sum w[k]*x[n-k], x[negative] = 0.
  int wv[3], xv[NS], yv[NS];

  function automatic void compute_ref(input int kl);
    for (int n = 0; n < NS; n++) begin
      int s = 0;
      for (int k = 0; k < kl; k++) if (n - k >= 0) s += wv[k] * xv[n-k];
`ifdef CONV1D_SATURATE_EN
      yv[n] = (s > 65535) ? 65535 : s;
`else
      yv[n] = s % 65536;
`endif
    end
  endfunction

  function automatic logic [PD*DWO-1:0] exp_word(input int a);
    logic [15:0] lo, hi;
    lo = yv[2*a][15:0];
    hi = yv[2*a+1][15:0];
    return {hi, lo};
  endfunction

  task automatic load3();
    for (int a = 0; a < 16; a++) begin
      kmem3[a] = PD*DWI'($urandom);
      xmem3[a] = {xv[2*a+1][7:0], xv[2*a][7:0]};
    end
    kmem3[0] = {wv[1][7:0], wv[0][7:0]};
    kmem3[1][7:0] = wv[2][7:0];
    compute_ref(3);
  endtask

  task automatic clear_logs();
    k_cyc.delete(); k_addr.delete(); i_cyc.delete(); i_addr.delete();
    w_cyc.delete(); w_addr.delete(); w_data.delete(); d_cyc.delete();
    busy_first = -1; busy_last = -1; zviol = 0; csviol = 0;
  endtask

  task automatic start3(input bit hold, output int t0);
    @(negedge clk);
    clear_logs();
    bus3.Start = 1'b1;
    t0 = cyc + 1;
    if (!hold) begin @(negedge clk); bus3.Start = 1'b0; end
  endtask

  task automatic wait_done3(input int ndone, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (d_cyc.size() >= ndone) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [51:0] o3, o1;
    repeat (3) @(negedge clk);
    o3 = {bus3.Busy, bus3.Done, bus3.Kern_Chip_Select, bus3.Kern_En_Read, bus3.Kern_Read_Addr,
          bus3.In_Chip_Select, bus3.In_En_Read, bus3.In_Read_Addr, bus3.Out_Chip_Select,
          bus3.Out_En_Write, bus3.Out_Write_Addr, bus3.Out_Write_Data};
    o1 = {bus1.Busy, bus1.Done, bus1.Kern_Chip_Select, bus1.Kern_En_Read, bus1.Kern_Read_Addr,
          bus1.In_Chip_Select, bus1.In_En_Read, bus1.In_Read_Addr, bus1.Out_Chip_Select,
          bus1.Out_En_Write, bus1.Out_Write_Addr, bus1.Out_Write_Data};
    checks++; if (o3 !== '0) begin errors++; $display("FAIL reset_outs3: got %h expected 0", o3); end
    checks++; if (o1 !== '0) begin errors++; $display("FAIL reset_outs1: got %h expected 0", o1); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int t0; bit ok;
    for (int k = 0; k < 3; k++) wv[k] = k + 1;
    for (int n = 0; n < NS; n++) xv[n] = n + 1;
    load3();
    start3(1'b0, t0);
    wait_done3(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no Done expected Done"); end
    checks++; if (w_cyc.size() != NW) begin errors++; $display("FAIL basic_nwrites: got %0d expected %0d", w_cyc.size(), NW); end
    else begin
      for (int a = 0; a < NW; a++) begin
        checks++;
        if (w_addr[a] != a || w_data[a] !== exp_word(a)) begin
          errors++; $display("FAIL basic_word%0d: got addr %0d data %h expected addr %0d data %h", a, w_addr[a], w_data[a], a, exp_word(a));
        end
      end
      checks++; if (w_data[0] !== {16'd4, 16'd1}) begin errors++; $display("FAIL basic_first: got %h expected 00040001", w_data[0]); end
      checks++; if (w_data[NW-1] !== {16'd184, 16'd178}) begin errors++; $display("FAIL basic_last: got %h expected 00b800b2", w_data[NW-1]); end
      checks++; if (w_cyc[0] - t0 + 1 != 5) begin errors++; $display("FAIL basic_first_write_cycle: got %0d expected 5", w_cyc[0] - t0 + 1); end
    end
    checks++; if (d_cyc.size() != 1 || d_cyc[0] - t0 + 1 != 21) begin
      errors++; $display("FAIL basic_done_cycle: got n=%0d rel=%0d expected n=1 rel=21", d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] - t0 + 1 : -1);
    end
    checks++; if (busy_first - t0 + 1 != 1 || busy_last - t0 + 1 != 20) begin
      errors++; $display("FAIL basic_busy: got %0d..%0d expected 1..20", busy_first - t0 + 1, busy_last - t0 + 1);
    end
  endtask

  task automatic test_addr_seq();
    int t0; bit ok;
    for (int k = 0; k < 3; k++) wv[k] = k + 1;
    for (int n = 0; n < NS; n++) xv[n] = n + 1;
    load3();
    start3(1'b0, t0);
    wait_done3(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL addr_timeout: got no Done expected Done"); end
    checks++; if (k_addr.size() != 2) begin errors++; $display("FAIL addr_kern_count: got %0d expected 2", k_addr.size()); end
    else for (int i = 0; i < 2; i++) begin
      checks++; if (k_addr[i] != i || k_cyc[i] - t0 + 1 != i + 1) begin
        errors++; $display("FAIL addr_kern%0d: got addr %0d cyc %0d expected addr %0d cyc %0d", i, k_addr[i], k_cyc[i] - t0 + 1, i, i + 1);
      end
    end
    checks++; if (i_addr.size() != NW || w_addr.size() != NW) begin
      errors++; $display("FAIL addr_in_count: got reads %0d writes %0d expected %0d", i_addr.size(), w_addr.size(), NW);
    end else for (int i = 0; i < NW; i++) begin
      checks++; if (i_addr[i] != i || i_cyc[i] - t0 + 1 != 3 + i) begin
        errors++; $display("FAIL addr_in%0d: got addr %0d cyc %0d expected addr %0d cyc %0d", i, i_addr[i], i_cyc[i] - t0 + 1, i, 3 + i);
      end
      checks++; if (w_cyc[i] - 2 != i_cyc[i] || w_addr[i] != i_addr[i]) begin
        errors++; $display("FAIL addr_wr%0d: got addr %0d lag %0d expected addr %0d lag 2", i, w_addr[i], w_cyc[i] - i_cyc[i], i_addr[i]);
      end
    end
    checks++; if (zviol != 0 || csviol != 0) begin
      errors++; $display("FAIL addr_idle_bus: got zero-data viol %0d cs viol %0d expected 0 0", zviol, csviol);
    end
  endtask

  task automatic test_random();
    int t0; bit ok;
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 3; k++) wv[k] = int'($urandom_range(0, 255));
      for (int n = 0; n < NS; n++) xv[n] = int'($urandom_range(0, 255));
      load3();
      start3(1'b0, t0);
      wait_done3(1, ok);
      checks++; if (!ok || w_data.size() != NW) begin errors++; $display("FAIL rand%0d_count: got %0d writes expected %0d", it, w_data.size(), NW); end
      else for (int a = 0; a < NW; a++) begin
        checks++; if (w_data[a] !== exp_word(a)) begin
          errors++; $display("FAIL rand%0d_word%0d: got %h expected %h", it, a, w_data[a], exp_word(a));
        end
      end
    end
  endtask

  task automatic test_overflow();
    int t0; bit ok;
    logic [15:0] e1, e5;
`ifdef CONV1D_SATURATE_EN
    e1 = 16'd65535; e5 = 16'd65535;
`else
    e1 = 16'd64514; e5 = 16'd64003;
`endif
    for (int k = 0; k < 3; k++) wv[k] = 255;
    for (int n = 0; n < NS; n++) xv[n] = 255;
    load3();
    start3(1'b0, t0);
    wait_done3(1, ok);
    checks++; if (!ok || w_data.size() != NW) begin errors++; $display("FAIL ovf_count: got %0d writes expected %0d", w_data.size(), NW); end
    else begin
      checks++; if (w_data[0][15:0] !== 16'd65025 || w_data[0][31:16] !== e1) begin
        errors++; $display("FAIL ovf_word0: got %h expected %h", w_data[0], {e1, 16'd65025});
      end
      checks++; if (w_data[5] !== {e5, e5}) begin errors++; $display("FAIL ovf_word5: got %h expected %h", w_data[5], {e5, e5}); end
      for (int a = 0; a < NW; a++) begin
        checks++; if (w_data[a] !== exp_word(a)) begin errors++; $display("FAIL ovf_word%0d: got %h expected %h", a, w_data[a], exp_word(a)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0, nw, ni, nk; bit ok, hit;
    logic [51:0] o3;
    for (int k = 0; k < 3; k++) wv[k] = int'($urandom_range(0, 255));
    for (int n = 0; n < NS; n++) xv[n] = int'($urandom_range(0, 255));
    load3();
    start3(1'b0, t0);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus3.In_En_Read && bus3.In_Read_Addr == 4'd5) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach: got no read of addr 5 expected one"); end
    rst = 1'b1;
    @(negedge clk);
    o3 = {bus3.Busy, bus3.Done, bus3.Kern_Chip_Select, bus3.Kern_En_Read, bus3.Kern_Read_Addr,
          bus3.In_Chip_Select, bus3.In_En_Read, bus3.In_Read_Addr, bus3.Out_Chip_Select,
          bus3.Out_En_Write, bus3.Out_Write_Addr, bus3.Out_Write_Data};
    checks++; if (o3 !== '0) begin errors++; $display("FAIL rstmid_outs: got %h expected 0", o3); end
    nw = w_cyc.size(); ni = i_cyc.size(); nk = k_cyc.size();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (w_cyc.size() != nw || i_cyc.size() != ni || k_cyc.size() != nk || d_cyc.size() != 0) begin
      errors++; $display("FAIL rstmid_quiet: got extra writes %0d reads %0d done %0d expected 0 0 0", w_cyc.size() - nw, i_cyc.size() - ni, d_cyc.size());
    end
    start3(1'b0, t0);
    wait_done3(1, ok);
    checks++; if (!ok || w_data.size() != NW || d_cyc[0] - t0 + 1 != 21) begin
      errors++; $display("FAIL rstmid_rerun: got %0d writes expected %0d with Done at 21", w_data.size(), NW);
    end else for (int a = 0; a < NW; a++) begin
      checks++; if (w_data[a] !== exp_word(a)) begin errors++; $display("FAIL rstmid_word%0d: got %h expected %h", a, w_data[a], exp_word(a)); end
    end
  endtask

  task automatic test_start_busy();
    int t0; bit ok;
    for (int k = 0; k < 3; k++) wv[k] = int'($urandom_range(0, 255));
    for (int n = 0; n < NS; n++) xv[n] = int'($urandom_range(0, 255));
    load3();
    start3(1'b0, t0);
    repeat (7) @(negedge clk);
    bus3.Start = 1'b1;
    @(negedge clk);
    bus3.Start = 1'b0;
    wait_done3(1, ok);
    repeat (5) @(negedge clk);
    checks++; if (!ok || d_cyc.size() != 1 || d_cyc[0] - t0 + 1 != 21) begin
      errors++; $display("FAIL busy_start_done: got n=%0d expected one Done at 21", d_cyc.size());
    end
    checks++; if (w_data.size() != NW) begin errors++; $display("FAIL busy_start_writes: got %0d expected %0d", w_data.size(), NW); end
    else for (int a = 0; a < NW; a++) begin
      checks++; if (w_data[a] !== exp_word(a)) begin errors++; $display("FAIL busy_start_word%0d: got %h expected %h", a, w_data[a], exp_word(a)); end
    end
    // Start held high: second run only after the return to IDLE.
    start3(1'b1, t0);
    wait_done3(2, ok);
    bus3.Start = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (!ok || d_cyc.size() != 2 || d_cyc[0] - t0 + 1 != 21 || d_cyc[1] - t0 + 1 != 43) begin
      errors++; $display("FAIL held_start_done: got n=%0d expected Done at 21 and 43", d_cyc.size());
    end
  endtask

  task automatic test_single_tap();
    int t0; bit ok;
    wv[0] = 2;
    for (int n = 0; n < NS; n++) xv[n] = int'($urandom_range(0, 255));
    for (int a = 0; a < 16; a++) begin
      kmem1[a] = PD*DWI'($urandom);
      xmem1[a] = {xv[2*a+1][7:0], xv[2*a][7:0]};
    end
    kmem1[0][7:0] = 8'd2;
    compute_ref(1);
    @(negedge clk);
    k1_cnt = 0; w1_cyc.delete(); w1_data.delete(); d1_cyc.delete();
    bus1.Start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    bus1.Start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (d1_cyc.size() > 0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || d1_cyc[0] - t0 + 1 != 20) begin
      errors++; $display("FAIL tap1_done: got rel %0d expected 20", ok ? d1_cyc[0] - t0 + 1 : -1);
    end
    checks++; if (k1_cnt != 1) begin errors++; $display("FAIL tap1_kreads: got %0d expected 1", k1_cnt); end
    checks++; if (w1_data.size() != NW) begin errors++; $display("FAIL tap1_writes: got %0d expected %0d", w1_data.size(), NW); end
    else for (int a = 0; a < NW; a++) begin
      checks++; if (w1_data[a] !== exp_word(a) || w1_data[a][15:0] !== 16'(2 * xv[2*a])) begin
        errors++; $display("FAIL tap1_word%0d: got %h expected %h", a, w1_data[a], exp_word(a));
      end
    end
  endtask

  initial begin
    bus3.Start = 1'b0;
    bus1.Start = 1'b0;
    test_reset();
    test_basic();
    test_addr_seq();
    test_random();
    test_overflow();
    test_reset_mid();
    test_start_busy();
    test_single_tap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
